idma_desc64_reshaper_mc: RTL and testbench



---
 rtl/idma_desc64_reshaper_mc.sv | 195 +++++++++++++++++++
 tb/tb_idma_desc64_reshaper_mc.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_desc64_reshaper_mc.sv
// idma_desc64_reshaper_mc: multi-channel desc64 -> iDMA backend request reshaper.
// Round-robin arbitration over NumChannels descriptor inputs; reshaped
// requests with next-pointer/IRQ/channel sideband are buffered in a FIFO.
// Optional feature macro: IDMA_DESC64_RESHAPER_DROP_ZERO_LEN_EN
//   (zero-length descriptors without IRQ are consumed but not buffered).

package idma_desc64_reshaper_mc_pkg;
  typedef logic [63:0] addr_t;

  typedef struct packed {
    logic [1:0] burst;
    logic [3:0] cache;
    logic       lock;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } axi_opt_t;

  typedef struct packed {
    logic       decouple_aw;
    logic       decouple_rw;
    logic [2:0] src_max_llen;
    logic [2:0] dst_max_llen;
    logic       src_reduce_len;
    logic       dst_reduce_len;
  } backend_opt_t;

  typedef struct packed {
    logic [2:0]   src_protocol;
    logic [2:0]   dst_protocol;
    logic [7:0]   axi_id;
    axi_opt_t     src;
    axi_opt_t     dst;
    backend_opt_t beo;
    logic         last;
  } opt_t;

  typedef struct packed {
    logic [31:0] length;
    addr_t       src_addr;
    addr_t       dst_addr;
    opt_t        opt;
  } idma_req_t;

  typedef struct packed {
    logic [31:0] flags;
    logic [31:0] length;
    addr_t       next;
    addr_t       src_addr;
    addr_t       dest_addr;
  } descriptor_t;
endpackage

module idma_desc64_reshaper_mc #(
  parameter int unsigned NumChannels  = 2,
  parameter int unsigned FifoDepth    = 4,
  parameter type         idma_req_t   = idma_desc64_reshaper_mc_pkg::idma_req_t,
  parameter type         addr_t       = idma_desc64_reshaper_mc_pkg::addr_t,
  parameter type         descriptor_t = idma_desc64_reshaper_mc_pkg::descriptor_t,
  localparam int unsigned ChanW = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  localparam int unsigned PtrW  = $clog2(FifoDepth),
  localparam int unsigned FillW = PtrW + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  descriptor_t [NumChannels-1:0]      desc_i,
  input  logic        [NumChannels-1:0]      desc_valid_i,
  output logic        [NumChannels-1:0]      desc_ready_o,
  output idma_req_t                          idma_req_o,
  output addr_t                              next_addr_o,
  output logic                               do_irq_o,
  output logic        [ChanW-1:0]            chan_o,
  output logic                               req_valid_o,
  input  logic                               req_ready_i,
  output logic        [FillW-1:0]            fill_o
);

  logic [ChanW-1:0] r_rr_ptr;
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [FillW-1:0] r_fill;

  idma_req_t        r_mem_req  [FifoDepth];
  addr_t            r_mem_next [FifoDepth];
  logic             r_mem_irq  [FifoDepth];
  logic [ChanW-1:0] r_mem_chan [FifoDepth];

  logic             w_full;
  logic             w_empty;
  logic             w_grant_vld;
  logic [ChanW-1:0] w_grant_idx;
  logic [ChanW-1:0] w_cand;
  descriptor_t      w_sel_desc;
  idma_req_t        w_req;
  logic             w_drop;
  logic             w_push;
  logic             w_pop;
  logic             w_unused;

  assign w_full  = (r_fill == FillW'(FifoDepth));
  assign w_empty = (r_fill == '0);

  // Round-robin search: first valid channel at or after the pointer, wrapping.
  // Reset is folded in so no handshake can complete while rst_i is high.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    if (!rst_i && !w_full) begin
      for (int unsigned i = 0; i < NumChannels; i++) begin
        w_cand = ChanW'((32'(r_rr_ptr) + i) % NumChannels);
        if (!w_grant_vld && desc_valid_i[w_cand]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = w_cand;
        end
      end
    end
  end

  // One-hot ready on the granted channel only.
  always_comb begin
    desc_ready_o = '0;
    if (w_grant_vld) desc_ready_o[w_grant_idx] = 1'b1;
  end

  assign w_sel_desc = desc_i[w_grant_idx];
  assign w_unused   = ^w_sel_desc.flags[31:30];

  // Field-by-field reshape of the granted descriptor into a backend request.
  always_comb begin
    w_req                        = '0;
    w_req.length                 = w_sel_desc.length;
    w_req.src_addr               = w_sel_desc.src_addr;
    w_req.dst_addr               = w_sel_desc.dest_addr;
    w_req.opt.axi_id             = w_sel_desc.flags[23:16];
    w_req.opt.src.burst          = w_sel_desc.flags[2:1];
    w_req.opt.dst.burst          = w_sel_desc.flags[4:3];
    w_req.opt.src.cache          = w_sel_desc.flags[11:8];
    w_req.opt.dst.cache          = w_sel_desc.flags[15:12];
    w_req.opt.beo.decouple_rw    = w_sel_desc.flags[5];
    w_req.opt.beo.decouple_aw    = w_sel_desc.flags[6];
    w_req.opt.beo.src_reduce_len = w_sel_desc.flags[7];
    w_req.opt.beo.dst_reduce_len = w_sel_desc.flags[7];
    w_req.opt.src_protocol       = w_sel_desc.flags[26:24];
    w_req.opt.dst_protocol       = w_sel_desc.flags[29:27];
  end

`ifdef IDMA_DESC64_RESHAPER_DROP_ZERO_LEN_EN
  assign w_drop = (w_sel_desc.length == '0) && !w_sel_desc.flags[0];
`else
  assign w_drop = 1'b0;
`endif

  assign w_push = w_grant_vld && !w_drop;
  assign w_pop  = !w_empty && req_ready_i;

  // FIFO payload storage; contents are qualified by r_fill so no reset needed.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_req[r_wptr]  <= w_req;
      r_mem_next[r_wptr] <= w_sel_desc.next;
      r_mem_irq[r_wptr]  <= w_sel_desc.flags[0];
      r_mem_chan[r_wptr] <= w_grant_idx;
    end
  end

  // FIFO pointers, occupancy and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_fill   <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      if (w_grant_vld) begin
        r_rr_ptr <= (w_grant_idx == ChanW'(NumChannels - 1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  assign req_valid_o = !w_empty;
  assign idma_req_o  = w_empty ? '0 : r_mem_req[r_rptr];
  assign next_addr_o = w_empty ? '0 : r_mem_next[r_rptr];
  assign do_irq_o    = w_empty ? 1'b0 : r_mem_irq[r_rptr];
  assign chan_o      = w_empty ? '0 : r_mem_chan[r_rptr];
  assign fill_o      = r_fill;

endmodule

// File: tb/tb_idma_desc64_reshaper_mc.sv
// Self-checking bench for idma_desc64_reshaper_mc with a queue-based model.
module tb_idma_desc64_reshaper_mc;
  import idma_desc64_reshaper_mc_pkg::*;

  localparam int N = 2;
  localparam int D = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  descriptor_t [N-1:0]    desc;
  logic        [N-1:0]    dvalid;
  logic        [N-1:0]    dready;
  idma_req_t              req;
  addr_t                  nxt;
  logic                   irq;
  logic        [0:0]      chan;
  logic                   rvalid;
  logic                   rready;
  logic        [2:0]      fill;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    idma_req_t req;
    addr_t     nxt;
    logic      irq;
    int        chan;
  } ent_t;

  ent_t          mq[$];
  int            mptr = 0;
  logic [N-1:0]  last_ready;

  always #5 clk = ~clk;

  idma_desc64_reshaper_mc #(
    .NumChannels(N),
    .FifoDepth  (D)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .desc_i      (desc),
    .desc_valid_i(dvalid),
    .desc_ready_o(dready),
    .idma_req_o  (req),
    .next_addr_o (nxt),
    .do_irq_o    (irq),
    .chan_o      (chan),
    .req_valid_o (rvalid),
    .req_ready_i (rready),
    .fill_o      (fill)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Request expected from a descriptor, written straight from the field mapping table.
  function automatic idma_req_t model_req(input descriptor_t d);
    idma_req_t r;
    r = '0;
    r.length                 = d.length;
    r.src_addr               = d.src_addr;
    r.dst_addr               = d.dest_addr;
    r.opt.axi_id             = d.flags[23:16];
    r.opt.src.burst          = d.flags[2:1];
    r.opt.dst.burst          = d.flags[4:3];
    r.opt.src.cache          = d.flags[11:8];
    r.opt.dst.cache          = d.flags[15:12];
    r.opt.beo.decouple_rw    = d.flags[5];
    r.opt.beo.decouple_aw    = d.flags[6];
    r.opt.beo.src_reduce_len = d.flags[7];
    r.opt.beo.dst_reduce_len = d.flags[7];
    r.opt.src_protocol       = d.flags[26:24];
    r.opt.dst_protocol       = d.flags[29:27];
    return r;
  endfunction

  function automatic bit model_drops(input descriptor_t d);
`ifdef IDMA_DESC64_RESHAPER_DROP_ZERO_LEN_EN
    return (d.length == 0) && (d.flags[0] == 1'b0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic descriptor_t rand_desc();
    descriptor_t d;
    d.flags     = $urandom;
    d.length    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    d.next      = {$urandom, $urandom};
    d.src_addr  = {$urandom, $urandom};
    d.dest_addr = {$urandom, $urandom};
    return d;
  endfunction

  function automatic descriptor_t tag_desc(input int k);
    descriptor_t d;
    d           = rand_desc();
    d.length    = 32'h100 + k;
    d.next      = 64'h1000 + k;
    return d;
  endfunction

  // One clock: compare DUT to model at the falling edge, advance the model, return at posedge+1.
  task automatic step();
    logic [N-1:0] er;
    int           g;
    ent_t         e;
    bit           pop;
    @(negedge clk);
    er = '0;
    g  = -1;
    if (!rst && mq.size() < D) begin
      for (int i = 0; i < N; i++) begin
        if (g < 0 && dvalid[(mptr + i) % N]) g = (mptr + i) % N;
      end
      if (g >= 0) er[g] = 1'b1;
    end
    last_ready = dready;
    chk("desc_ready", dready, er);
    chk("fill", fill, mq.size());
    chk("req_valid", rvalid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("idma_req", req, mq[0].req);
      chk("next_addr", nxt, mq[0].nxt);
      chk("do_irq", irq, mq[0].irq);
      chk("chan", chan, mq[0].chan);
    end else begin
      chk("idma_req_empty", req, '0);
      chk("next_addr_empty", nxt, '0);
    end
    if (rst) begin
      mq.delete();
      mptr = 0;
    end else begin
      pop = (mq.size() > 0) && rready;
      if (pop) void'(mq.pop_front());
      if (g >= 0) begin
        if (!model_drops(desc[g])) begin
          e.req  = model_req(desc[g]);
          e.nxt  = desc[g].next;
          e.irq  = desc[g].flags[0];
          e.chan = g;
          mq.push_back(e);
        end
        mptr = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    descriptor_t d;
    dvalid = '0;
    rready = 1'b0;
    for (int c = 0; c < N; c++) desc[c] = '0;

    // Reset state, valid asserted during reset must not be granted.
    dvalid = '1;
    do_reset();
    dvalid = '0;
    chk("reset_fill", fill, 3'd0);
    chk("reset_valid", rvalid, 1'b0);

    // Mapping example on channel 0.
    d           = '0;
    d.flags     = 32'h0A05_F3B5;
    d.length    = 32'h40;
    d.next      = 64'hDEAD_BEEF_0000_1000;
    desc[0]     = d;
    dvalid      = 2'b01;
    step();
    dvalid      = '0;
    chk("ex_valid", rvalid, 1'b1);
    chk("ex_axi_id", req.opt.axi_id, 8'h05);
    chk("ex_src_burst", req.opt.src.burst, 2'd2);
    chk("ex_dst_burst", req.opt.dst.burst, 2'd2);
    chk("ex_src_cache", req.opt.src.cache, 4'h3);
    chk("ex_dst_cache", req.opt.dst.cache, 4'hF);
    chk("ex_dec_rw", req.opt.beo.decouple_rw, 1'b1);
    chk("ex_dec_aw", req.opt.beo.decouple_aw, 1'b0);
    chk("ex_reduce", {req.opt.beo.src_reduce_len, req.opt.beo.dst_reduce_len}, 2'b11);
    chk("ex_src_proto", req.opt.src_protocol, 3'd2);
    chk("ex_dst_proto", req.opt.dst_protocol, 3'd1);
    chk("ex_length", req.length, 32'h40);
    chk("ex_irq", irq, 1'b1);
    chk("ex_chan", chan, 1'b0);
    rready = 1'b1;
    step();
    rready = 1'b0;

    // Alternating grants with both channels always valid.
    do_reset();
    rready = 1'b1;
    dvalid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      desc[0] = tag_desc(2 * k);
      desc[1] = tag_desc(2 * k + 1);
      step();
      chk("rr_ready", last_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_chan", chan, k % 2);
    end
    dvalid = '0;
    rready = 1'b0;

    // Fill to full, fifth descriptor held off, then drained in order.
    do_reset();
    dvalid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      desc[0] = tag_desc(k);
      step();
    end
    chk("full_fill", fill, 3'd4);
    chk("full_ready5", last_ready, 2'b00);
    rready = 1'b1;
    step();
    chk("drain_ready_at_full", last_ready, 2'b00);
    chk("drain_fill3", fill, 3'd3);
    step();
    chk("fifth_accepted", last_ready, 2'b01);
    chk("fifth_fill", fill, 3'd3);
    dvalid = '0;
    repeat (4) step();
    rready = 1'b0;

    // Simultaneous push and pop at fill 2.
    do_reset();
    dvalid = 2'b01;
    desc[0] = tag_desc(0); step();
    desc[0] = tag_desc(1); step();
    rready = 1'b1;
    desc[0] = tag_desc(2); step();
    chk("pp_fill", fill, 3'd2);
    chk("pp_head", nxt, 64'h1001);
    dvalid = '0;
    rready = 1'b0;

    // Reset with three buffered entries.
    do_reset();
    dvalid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      desc[0] = tag_desc(k);
      step();
    end
    dvalid = 2'b11;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_fill", fill, 3'd0);
    chk("mid_rst_valid", rvalid, 1'b0);
    step();
    chk("mid_rst_grant0", last_ready, 2'b01);
    dvalid = '0;

    // Zero-length descriptors, with and without IRQ.
    do_reset();
    dvalid = 2'b01;
    d = tag_desc(0); d.length = 0; d.flags[0] = 1'b0; desc[0] = d;
    step();
`ifdef IDMA_DESC64_RESHAPER_DROP_ZERO_LEN_EN
    chk("zl_drop_fill", fill, 3'd0);
`else
    chk("zl_keep_fill", fill, 3'd1);
`endif
    d = tag_desc(1); d.length = 0; d.flags[0] = 1'b1; desc[0] = d;
    step();
    dvalid = '0;
`ifdef IDMA_DESC64_RESHAPER_DROP_ZERO_LEN_EN
    chk("zl_irq_fill", fill, 3'd1);
    chk("zl_irq_head", irq, 1'b1);
    chk("zl_irq_len", req.length, 32'd0);
`else
    chk("zl_irq_fill", fill, 3'd2);
`endif

    // Randomized traffic against the queue model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) desc[c] = rand_desc();
      dvalid = N'($urandom);
      rready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
